mem_req_arbiter: RTL and testbench
==================================

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 2, number of requesters (index 0 = core, 1 = matrix accelerator); ADDR_WIDTH, default 64, address width; DATA_WIDTH, default 64, data width; RSP_DEPTH, default 4, outstanding-read capacity.
REQ-002 Port clk SHALL be an input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit, asynchronous active-high reset.
REQ-004 Requester-side ports SHALL be:
- req_valid, input, NUM_REQ bits, beat request per requester.
- req_ready, output, NUM_REQ bits, beat accepted per requester.
- req_addr, input, NUM_REQ x ADDR_WIDTH, beat address.
- req_we, input, NUM_REQ bits, 1 = write.
- req_wdata, input, NUM_REQ x DATA_WIDTH, write data.
- req_be, input, NUM_REQ x DATA_WIDTH/8, byte enables.
- req_last, input, NUM_REQ bits, final beat of a locked sequence.
- rsp_valid, output, NUM_REQ bits, read data valid per requester.
- rsp_rdata, output, DATA_WIDTH, read data shared by all requesters, qualified by rsp_valid.
REQ-005 Memory-side ports SHALL be: mem_valid, output, 1; mem_ready, input, 1; mem_addr, output, ADDR_WIDTH; mem_we, output, 1; mem_wdata, output, DATA_WIDTH; mem_be, output, DATA_WIDTH/8; mem_rvalid, input, 1, in-order read return; mem_rdata, input, DATA_WIDTH.
REQ-006 Port err SHALL be an output, 1 bit, sticky flag set when a read response arrives with no outstanding read.

Function
REQ-007 The FSM SHALL have two states:
- IDLE: arbitrating.
- LOCKED: the grant is held by the index in a lock_idx register.
REQ-008 In IDLE the winner SHALL be the first i with req_valid[i] set, searching round-robin from rr_ptr upward with wrap-around.
REQ-009 Forwarding SHALL be combinational with zero latency: mem_valid equals req_valid[winner] & ~blocked; the mem_* payload equals the winner's payload; req_ready[winner] equals mem_ready & mem_valid; all other req_ready bits are 0.
REQ-010 blocked SHALL be asserted when the winner's beat is a read and the response FIFO is full; write beats are never blocked.
REQ-011 When a beat is accepted with req_last=0, the block SHALL move to LOCKED with lock_idx = winner and leave rr_ptr unchanged.
REQ-012 While in LOCKED only lock_idx SHALL be eligible, even if it deasserts req_valid; other requesters wait.
REQ-013 When a beat is accepted with req_last=1, the block SHALL go to (or stay in) IDLE and set rr_ptr = (winner+1) mod NUM_REQ.
REQ-014 Each accepted read beat SHALL push the winner index into the response FIFO (depth RSP_DEPTH); full is evaluated on registered state only, so a push is blocked when full even if a pop occurs in the same cycle.
REQ-015 On mem_rvalid with a non-empty FIFO, the block SHALL pop the head, assert rsp_valid[head] for exactly that cycle, and drive rsp_rdata = mem_rdata; there is no backpressure to memory.
REQ-016 On mem_rvalid with an empty FIFO, the response SHALL be dropped, err set, and err hold until reset.
REQ-017 A push and a pop in the same cycle on a non-full, non-empty FIFO SHALL leave the occupancy unchanged.

Reset
REQ-018 While rst is high: state = IDLE, rr_ptr = 0, lock_idx = 0, FIFO empty, err = 0, and mem_valid, req_ready and rsp_valid are forced to 0.
REQ-019 Reset asserted mid-lock or with reads outstanding SHALL discard all state; responses arriving after reset release set err.

Configuration
REQ-020 With MEM_ARB_PRIO_EN defined, requester 0 SHALL win whenever its req_valid is set in IDLE (fixed priority over round-robin), and the round-robin search SHALL apply only among the other requesters; LOCKED behaviour is unchanged.
REQ-021 Without MEM_ARB_PRIO_EN, pure round-robin per REQ-008 SHALL apply.

Structure
REQ-022 Package mem_arb_pkg SHALL hold the FSM state enum, a requester-index typedef of width $clog2(NUM_REQ), and the RSP_DEPTH default.
REQ-023 The response FIFO SHALL be sub-module mem_arb_rsp_fifo: push/pop interface, full/empty outputs, registered pointers.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Both requesters issue continuous single writes (last=1), mem_ready=1 -> grants alternate 0,1,0,1.
- Requester 1 issues a 4-beat burst (last on beat 4) while requester 0 is also valid -> four consecutive grants to 1, then 0.
- Five back-to-back reads from requester 0, RSP_DEPTH=4, no mem_rvalid -> four accepted, fifth stalled (mem_valid=0); one mem_rvalid -> fifth accepted the next cycle.
- Reads issued by 0, 1, 0, then three mem_rvalid with rdata A, B, C -> rsp_valid[0] with A, rsp_valid[1] with B, rsp_valid[0] with C.
- mem_rvalid with the FIFO empty -> err=1 and held until rst.
- With MEM_ARB_PRIO_EN, both valid and continuous -> requester 0 always granted; rst mid-burst -> state IDLE and outputs 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory request arbiter: FSM state,
// requester index type and response-queue depth.
package mem_arb_pkg;

  localparam int NUM_REQ_DEFAULT   = 2;
  localparam int RSP_DEPTH_DEFAULT = 4;

  // Index width that stays legal for a single-requester build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int REQ_IDX_W = idx_width(NUM_REQ_DEFAULT);

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester-side and memory-side bus of the arbiter. The slave modport is the
// arbiter's view; the master modport is the requesters plus memory model.
interface mem_req_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);

  // A beat transfers on any rising edge where valid and ready are both high;
  // valid never waits on ready, and ready may depend combinationally on valid.
  // Read returns (mem_rvalid, rsp_valid) are single-cycle pulses with no ready.
  logic [NUM_REQ-1:0]                   req_valid;
  logic [NUM_REQ-1:0]                   req_ready;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr;
  logic [NUM_REQ-1:0]                   req_we;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_wdata;
  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0] req_be;
  logic [NUM_REQ-1:0]                   req_last;
  logic [NUM_REQ-1:0]                   rsp_valid;
  logic [DATA_WIDTH-1:0]                rsp_rdata;

  logic                    mem_valid;
  logic                    mem_ready;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic                    mem_rvalid;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_be, req_last,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_valid, mem_addr, mem_we, mem_wdata, mem_be,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_be, req_last,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_valid, mem_addr, mem_we, mem_wdata, mem_be,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_arb_rsp_fifo.sv
// In-order queue of requester indices for outstanding reads. Full and empty
// come from registered occupancy only, so a pop never frees space for a push
// in the same cycle.
module mem_arb_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;

  logic [WIDTH-1:0] storage [DEPTH];
  ptr_t             wr_ptr_q;
  ptr_t             rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  function automatic ptr_t next_ptr(input ptr_t p);
    if (int'(p) == DEPTH - 1) begin
      return '0;
    end
    return p + ptr_t'(1);
  endfunction

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = storage[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      storage[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter from several requesters onto one memory port, with
// locked multi-beat sequences and in-order read-response routing.
// Build option: MEM_ARB_PRIO_EN gives requester 0 fixed priority while idle.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEFAULT,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int RSP_DEPTH  = RSP_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  mem_req_arbiter_if.slave bus,
  output logic             err,
  output arb_state_e       state_dbg
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int BE_W  = DATA_WIDTH / 8;

  typedef logic [IDX_W-1:0] idx_t;

  arb_state_e state_q;
  arb_state_e state_d;
  idx_t       rr_ptr_q;
  idx_t       rr_ptr_d;
  idx_t       lock_idx_q;
  idx_t       lock_idx_d;
  idx_t       winner;
  idx_t       fifo_head;
  logic       err_q;

  logic [NUM_REQ-1:0]    rr_mask;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;
  logic [BE_W-1:0]       win_be;
  logic                  win_we;
  logic                  win_last;
  logic                  blocked;
  logic                  accept;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;

  function automatic idx_t wrap_inc(input idx_t i);
    if (int'(i) == NUM_REQ - 1) begin
      return '0;
    end
    return i + idx_t'(1);
  endfunction

  // Requesters that take part in the round-robin search.
  always_comb begin
    rr_mask = '1;
`ifdef MEM_ARB_PRIO_EN
    if (NUM_REQ > 1) begin
      rr_mask[0] = 1'b0;
    end
`endif
  end

  // Winner selection: held index while locked, otherwise search from rr_ptr.
  always_comb begin
    logic found;
    idx_t cand;
    winner = rr_ptr_q;
    found  = 1'b0;
    cand   = '0;
    if (state_q == LOCKED) begin
      winner = lock_idx_q;
    end else begin
`ifdef MEM_ARB_PRIO_EN
      if (bus.req_valid[0]) begin
        winner = '0;
        found  = 1'b1;
      end
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = idx_t'((int'(rr_ptr_q) + k) % NUM_REQ);
        if (!found && bus.req_valid[cand] && rr_mask[cand]) begin
          winner = cand;
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    win_addr  = bus.req_addr[winner];
    win_wdata = bus.req_wdata[winner];
    win_be    = bus.req_be[winner];
    win_we    = bus.req_we[winner];
    win_last  = bus.req_last[winner];
  end

  // Zero-latency forwarding; reads stall only when the response queue is full.
  always_comb begin
    blocked       = ~win_we & fifo_full;
    bus.mem_valid = bus.req_valid[winner] & ~blocked & ~rst;
    bus.mem_addr  = win_addr;
    bus.mem_we    = win_we;
    bus.mem_wdata = win_wdata;
    bus.mem_be    = win_be;
    accept        = bus.mem_valid & bus.mem_ready;
    bus.req_ready = '0;
    if (accept) begin
      bus.req_ready[winner] = 1'b1;
    end
    fifo_push     = accept & ~win_we;
    fifo_pop      = bus.mem_rvalid & ~fifo_empty & ~rst;
    bus.rsp_valid = '0;
    if (fifo_pop) begin
      bus.rsp_valid[fifo_head] = 1'b1;
    end
    bus.rsp_rdata = bus.mem_rdata;
  end

  // A non-final beat pins the grant; the final beat moves the pointer past it.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    if (accept) begin
      if (win_last) begin
        state_d  = IDLE;
        rr_ptr_d = wrap_inc(winner);
      end else begin
        state_d    = LOCKED;
        lock_idx_d = winner;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      if (bus.mem_rvalid && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  mem_arb_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (IDX_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (winner),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: grants and read responses are checked
// against expectation queues filled as stimulus is driven.
module tb_mem_req_arbiter;
  import mem_arb_pkg::*;

  localparam int NR = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int RD = 4;

  localparam logic [AW-1:0] A0 = 64'h0000_0000_0000_0010;
  localparam logic [AW-1:0] A1 = 64'h1000_0000_0000_0010;

  logic       clk;
  logic       rst;
  logic       err;
  arb_state_e state_dbg;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0]    exp_grant_q[$];
  logic [DW+NR-1:0] exp_rsp_q[$];

  mem_req_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_req_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RSP_DEPTH  (RD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .err       (err),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester id lives in address bit 60.
  task automatic drive(input int i, input logic v, input logic we, input logic last,
                       input logic [AW-1:0] a);
    bus.req_valid[i] = v;
    bus.req_we[i]    = we;
    bus.req_last[i]  = last;
    bus.req_addr[i]  = a;
    bus.req_wdata[i] = ~a;
    bus.req_be[i]    = '1;
  endtask

  task automatic check_outputs();
    logic [AW-1:0]    ea;
    logic [DW+NR-1:0] er;
    if (bus.mem_valid && bus.mem_ready) begin
      if (exp_grant_q.size() == 0) begin
        check("grant_unexpected", 128'(bus.mem_valid), 128'(0));
      end else begin
        ea = exp_grant_q.pop_front();
        check("grant_addr", 128'(bus.mem_addr), 128'(ea));
        check("grant_ready", 128'(bus.req_ready), 128'(NR'(1) << ea[60]));
      end
    end
    if (bus.rsp_valid != '0) begin
      if (exp_rsp_q.size() == 0) begin
        check("rsp_unexpected", 128'(bus.rsp_valid), 128'(0));
      end else begin
        er = exp_rsp_q.pop_front();
        check("rsp", 128'({bus.rsp_valid, bus.rsp_rdata}), 128'(er));
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    half();
    adv();
  endtask

  task automatic drained(input string tag);
    check({tag, "_grant_q"}, 128'(exp_grant_q.size()), 128'(0));
    check({tag, "_rsp_q"}, 128'(exp_rsp_q.size()), 128'(0));
  endtask

  task automatic rvalid(input logic v, input logic [DW-1:0] d);
    bus.mem_rvalid = v;
    bus.mem_rdata  = d;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = '0; bus.req_we = '0; bus.req_last = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_be = '0;
    bus.mem_ready = 1'b1;
    rvalid(1'b0, '0);

    // Reset: outputs forced low even with requests and a read return present.
    adv();
    drive(0, 1'b1, 1'b1, 1'b1, A0);
    drive(1, 1'b1, 1'b1, 1'b1, A1);
    rvalid(1'b1, 64'hdead);
    half();
    check("rst_mem_valid", 128'(bus.mem_valid), 128'(0));
    check("rst_req_ready", 128'(bus.req_ready), 128'(0));
    check("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    check("rst_state", 128'(state_dbg), 128'(IDLE));
    check("rst_err", 128'(err), 128'(0));
    adv();
    rvalid(1'b0, '0);
    rst = 1'b0;

    // Both requesters streaming single writes.
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_PRIO_EN
      exp_grant_q.push_back(A0);
`else
      exp_grant_q.push_back((i % 2 == 0) ? A0 : A1);
`endif
      step();
    end
    drive(0, 1'b0, 1'b1, 1'b1, A0);
    drive(1, 1'b0, 1'b1, 1'b1, A1);
    drained("rr");

    // Locked 4-beat burst from requester 1 with requester 0 contending.
    for (int b = 0; b < 4; b++) begin
      drive(1, 1'b1, 1'b1, (b == 3), 64'h1000_0000_0000_0200 + AW'(b));
      if (b > 0) drive(0, 1'b1, 1'b1, 1'b1, A0);
      exp_grant_q.push_back(64'h1000_0000_0000_0200 + AW'(b));
      step();
      if (b == 0) begin
        check("burst_locked", 128'(state_dbg), 128'(LOCKED));
        drive(1, 1'b0, 1'b1, 1'b0, 64'h1000_0000_0000_0201);
        drive(0, 1'b1, 1'b1, 1'b1, A0);
        half();
        check("lock_hold_no_grant", 128'(bus.mem_valid), 128'(0));
        adv();
      end
    end
    drive(1, 1'b0, 1'b1, 1'b1, A1);
    check("burst_released", 128'(state_dbg), 128'(IDLE));
    exp_grant_q.push_back(A0);
    step();
    drive(0, 1'b0, 1'b1, 1'b1, A0);
    drained("burst");

    // Reads from requester 0 until the response queue fills.
    for (int k = 0; k < RD; k++) begin
      drive(0, 1'b1, 1'b0, 1'b1, 64'h0000_0000_0000_0300 + AW'(k));
      exp_grant_q.push_back(64'h0000_0000_0000_0300 + AW'(k));
      step();
    end
    drive(0, 1'b1, 1'b0, 1'b1, 64'h0000_0000_0000_0304);
    half();
    check("full_stall", 128'(bus.mem_valid), 128'(0));
    adv();
    rvalid(1'b1, 64'hd000_0000_0000_0000);
    exp_rsp_q.push_back({2'b01, 64'hd000_0000_0000_0000});
    half();
    check("full_stall_pop_cycle", 128'(bus.mem_valid), 128'(0));
    adv();
    rvalid(1'b0, '0);
    exp_grant_q.push_back(64'h0000_0000_0000_0304);
    step();
    drive(0, 1'b0, 1'b0, 1'b1, A0);
    for (int j = 1; j <= RD; j++) begin
      rvalid(1'b1, 64'hd000_0000_0000_0000 + DW'(j));
      exp_rsp_q.push_back({2'b01, 64'hd000_0000_0000_0000 + DW'(j)});
      step();
    end
    rvalid(1'b0, '0);
    drained("fill");

    // Reads by 0, 1, 0; the first return overlaps the third read.
    drive(0, 1'b1, 1'b0, 1'b1, 64'h0000_0000_0000_0400);
    exp_grant_q.push_back(64'h0000_0000_0000_0400);
    step();
    drive(0, 1'b0, 1'b0, 1'b1, A0);
    drive(1, 1'b1, 1'b0, 1'b1, 64'h1000_0000_0000_0400);
    exp_grant_q.push_back(64'h1000_0000_0000_0400);
    step();
    drive(1, 1'b0, 1'b0, 1'b1, A1);
    drive(0, 1'b1, 1'b0, 1'b1, 64'h0000_0000_0000_0401);
    exp_grant_q.push_back(64'h0000_0000_0000_0401);
    rvalid(1'b1, 64'haaaa_aaaa_aaaa_aaaa);
    exp_rsp_q.push_back({2'b01, 64'haaaa_aaaa_aaaa_aaaa});
    step();
    drive(0, 1'b0, 1'b0, 1'b1, A0);
    rvalid(1'b1, 64'hbbbb_bbbb_bbbb_bbbb);
    exp_rsp_q.push_back({2'b10, 64'hbbbb_bbbb_bbbb_bbbb});
    step();
    rvalid(1'b1, 64'hcccc_cccc_cccc_cccc);
    exp_rsp_q.push_back({2'b01, 64'hcccc_cccc_cccc_cccc});
    step();
    rvalid(1'b0, '0);
    drained("route");

    // Stray read return sets a sticky error.
    rvalid(1'b1, 64'h5555);
    half();
    check("stray_rsp_dropped", 128'(bus.rsp_valid), 128'(0));
    adv();
    rvalid(1'b0, '0);
    check("err_set", 128'(err), 128'(1));
    for (int i = 0; i < 3; i++) step();
    check("err_sticky", 128'(err), 128'(1));
    rst = 1'b1;
    #1;
    check("err_cleared", 128'(err), 128'(0));
    adv();
    rst = 1'b0;

    // Reset while locked with a read outstanding.
    drive(0, 1'b1, 1'b0, 1'b1, 64'h0000_0000_0000_0500);
    exp_grant_q.push_back(64'h0000_0000_0000_0500);
    step();
    drive(0, 1'b0, 1'b0, 1'b1, A0);
    drive(1, 1'b1, 1'b1, 1'b0, 64'h1000_0000_0000_0500);
    exp_grant_q.push_back(64'h1000_0000_0000_0500);
    step();
    check("midburst_locked", 128'(state_dbg), 128'(LOCKED));
    drive(1, 1'b1, 1'b1, 1'b0, 64'h1000_0000_0000_0501);
    drive(0, 1'b1, 1'b1, 1'b1, A0);
    rvalid(1'b1, 64'h7777);
    rst = 1'b1;
    #1;
    check("midrst_state", 128'(state_dbg), 128'(IDLE));
    check("midrst_mem_valid", 128'(bus.mem_valid), 128'(0));
    check("midrst_req_ready", 128'(bus.req_ready), 128'(0));
    check("midrst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    step();
    rst = 1'b0;
    drive(0, 1'b0, 1'b1, 1'b1, A0);
    drive(1, 1'b0, 1'b1, 1'b1, A1);
    half();
    check("post_rst_rsp_dropped", 128'(bus.rsp_valid), 128'(0));
    adv();
    rvalid(1'b0, '0);
    check("post_rst_err", 128'(err), 128'(1));
    drive(0, 1'b1, 1'b1, 1'b1, A0);
    drive(1, 1'b1, 1'b1, 1'b1, A1);
    exp_grant_q.push_back(A0);
    step();
    drive(0, 1'b0, 1'b1, 1'b1, A0);
    drive(1, 1'b0, 1'b1, 1'b1, A1);
    step();
    drained("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
